// File: rtl/sample_iterator_ctrl_if.sv
// ---------------------------------------------------------------------------
// sample_iterator_ctrl_if
// Bundles the setup-side triangle handoff (R13) and the sample-test-side
// sample stream (R14) of the sample iterator.
//
// Handshake semantics:
//   R13: setup presents tri/color/box/step with validTri_R13H=1 and must hold
//        them until halt_R13H=0; a triangle is taken in any cycle where
//        validTri_R13H=1 and halt_R13H=0.
//   R14: validSamp_R14H=1 marks sample_R14S as a real sample; while
//        halt_R14H=1 every R14 output holds, so a sample is consumed on each
//        clock edge where validSamp_R14H=1 and halt_R14H=0.
//
// Modports:
//   master - setup / sample-test side (drives R13 inputs and halt_R14H)
//   slave  - the iterator
// ---------------------------------------------------------------------------
interface sample_iterator_ctrl_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;      // [0]=ll, [1]=ur; [.][0]=x, [.][1]=y
    logic                                   validTri_R13H;
    logic [SIGFIG-1:0]                      step_R13U;
    logic                                   halt_R13H;
    logic                                   halt_R14H;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;   // [0]=x, [1]=y
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, step_R13U, halt_R14H,
        input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, step_R13U, halt_R14H,
        output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator_ctrl.sv
// ---------------------------------------------------------------------------
// sample_iterator_ctrl
// Takes one triangle plus bounding box from setup and walks every sample
// position in the box in raster order (x fastest, then y), issuing one
// sample/triangle pair per cycle to the sample test stage. Setup is
// back-pressured (halt_R13H) for the whole time a triangle is iterated.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active low
//   bus          sample_iterator_ctrl_if.slave (R13 triangle in, R14 samples out)
//   state_dbg_o  current FSM state (0=WAIT, 1=TEST)
// ---------------------------------------------------------------------------
module sample_iterator_ctrl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    sample_iterator_ctrl_if.slave       bus,
    output logic                        state_dbg_o
);

    // Positions carry RADIX fraction bits; at least one integer bit must remain.
    if (RADIX >= SIGFIG) begin : g_bad_radix
        $error("RADIX must be smaller than SIGFIG");
    end

    typedef enum logic {
        S_WAIT = 1'b0,
        S_TEST = 1'b1
    } state_t;

    state_t                                 state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic signed [SIGFIG-1:0]               llx_q, llx_d;
    logic signed [SIGFIG-1:0]               urx_q, urx_d;
    logic signed [SIGFIG-1:0]               ury_q, ury_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic signed [SIGFIG-1:0]               x_q, x_d;
    logic signed [SIGFIG-1:0]               y_q, y_d;
    logic                                   valid_q, valid_d;

    logic                                   accept;
    logic                                   box_legal;
    // One extra bit so stepping past the most positive coordinate cannot
    // wrap negative and restart the walk.
    logic signed [SIGFIG:0]                 nx, ny, urx_ext, ury_ext;

    assign accept = bus.validTri_R13H && (state_q == S_WAIT);

    assign box_legal = ($signed(bus.box_R13S[0][0]) <= $signed(bus.box_R13S[1][0])) &&
                       ($signed(bus.box_R13S[0][1]) <= $signed(bus.box_R13S[1][1])) &&
                       (bus.step_R13U != '0);

    assign nx      = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
    assign ny      = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
    assign urx_ext = $signed({urx_q[SIGFIG-1], urx_q});
    assign ury_ext = $signed({ury_q[SIGFIG-1], ury_q});

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;

        case (state_q)
            S_WAIT: begin
                valid_d = 1'b0;
                // An illegal box is still consumed (halt_R13H is low), just dropped.
                if (accept && box_legal) begin
                    state_d = S_TEST;
                    tri_d   = bus.tri_R13S;
                    color_d = bus.color_R13U;
                    llx_d   = bus.box_R13S[0][0];
                    urx_d   = bus.box_R13S[1][0];
                    ury_d   = bus.box_R13S[1][1];
                    step_d  = bus.step_R13U;
                    x_d     = bus.box_R13S[0][0];
                    y_d     = bus.box_R13S[0][1];
                    valid_d = 1'b1;
                end
            end
            S_TEST: begin
                if (!bus.halt_R14H) begin
                    if (nx <= urx_ext) begin
                        x_d = nx[SIGFIG-1:0];
                    end else if (ny <= ury_ext) begin
                        x_d = llx_q;
                        y_d = ny[SIGFIG-1:0];
                    end else begin
                        // Last sample retired; position is left as-is so the
                        // sample output keeps its final value in WAIT.
                        state_d = S_WAIT;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT;
            tri_q   <= '0;
            color_q <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.halt_R13H      = (state_q == S_TEST);
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = {y_q, x_q};
    assign bus.validSamp_R14H = valid_q;
    assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_sample_iterator_ctrl.sv
module tb_sample_iterator_ctrl;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_iterator_ctrl_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus();
    logic state_dbg;

    sample_iterator_ctrl #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .state_dbg_o (state_dbg)
    );

    int total  = 0;
    int passed = 0;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_exp;
    logic [COLORS-1:0][SIGFIG-1:0]          color_exp;

    int c1x[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int c1y[6] = '{0, 0, 0, 1024, 1024, 1024};

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic samp(input string tag, input int x, input int y);
        logic [SIGFIG-1:0] ex;
        logic [SIGFIG-1:0] ey;
        ex = x[SIGFIG-1:0];
        ey = y[SIGFIG-1:0];
        chk({tag, "_valid"}, bus.validSamp_R14H, 1);
        chk({tag, "_x"}, bus.sample_R14S[0], ex);
        chk({tag, "_y"}, bus.sample_R14S[1], ey);
    endtask

    // ---------------- drivers ----------------
    task automatic fill(input int seed);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                bus.tri_R13S[v][a] = SIGFIG'(seed * 256 + v * 16 + a + 1);
        for (int c = 0; c < COLORS; c++)
            bus.color_R13U[c] = SIGFIG'(seed * 4096 + c + 7);
    endtask

    task automatic load(input int llx, input int lly, input int urx, input int ury, input int stp);
        bus.box_R13S[0][0] = llx[SIGFIG-1:0];
        bus.box_R13S[0][1] = lly[SIGFIG-1:0];
        bus.box_R13S[1][0] = urx[SIGFIG-1:0];
        bus.box_R13S[1][1] = ury[SIGFIG-1:0];
        bus.step_R13U      = stp[SIGFIG-1:0];
    endtask

    // Presents a triangle for one cycle; returns at the negedge where the
    // first sample should be visible.
    task automatic send(input int llx, input int lly, input int urx, input int ury, input int stp);
        @(negedge clk);
        load(llx, lly, urx, ury, stp);
        bus.validTri_R13H = 1'b1;
        chk("send_halt13_low", bus.halt_R13H, 0);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid0"}, bus.validSamp_R14H, 0);
        chk({tag, "_halt13"}, bus.halt_R13H, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.validTri_R13H = 1'b0;
        bus.halt_R14H     = 1'b0;
        fill(0);
        load(0, 0, 0, 0, 0);

        // reset state
        #1;
        chk("rst_valid", bus.validSamp_R14H, 0);
        chk("rst_halt13", bus.halt_R13H, 0);
        chk("rst_sample", bus.sample_R14S, 0);
        chk("rst_tri", bus.tri_R14S, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;

        // case 1: 3x2 box, plus a stray validTri during iteration
        fill(1);
        tri_exp   = bus.tri_R13S;
        color_exp = bus.color_R13U;
        send(0, 0, 2048, 1024, 1024);
        fill(2);
        chk("c1_tri", bus.tri_R14S, tri_exp);
        chk("c1_color", bus.color_R14U, color_exp);
        chk("c1_halt13", bus.halt_R13H, 1);
        chk("c1_state", state_dbg, 1);
        samp("c1_s0", c1x[0], c1y[0]);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            samp("c1_s", c1x[i], c1y[i]);
            if (i == 2) begin
                load(4096, 4096, 8192, 8192, 512);
                bus.validTri_R13H = 1'b1;
            end
        end
        chk("c1_tri_hold", bus.tri_R14S, tri_exp);
        @(negedge clk);
        idle_chk("c1_end");
        chk("c1_end_x", bus.sample_R14S[0], 2048);
        chk("c1_end_y", bus.sample_R14S[1], 1024);
        chk("c1_end_state", state_dbg, 0);

        // case 2: downstream halt on the 3rd sample for 4 cycles
        fill(3);
        send(0, 0, 2048, 1024, 1024);
        samp("c2_s0", 0, 0);
        @(negedge clk);
        samp("c2_s1", 1024, 0);
        @(negedge clk);
        samp("c2_s2_h0", 2048, 0);
        bus.halt_R14H = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            samp("c2_s2_held", 2048, 0);
            chk("c2_halt13_held", bus.halt_R13H, 1);
        end
        @(negedge clk);
        samp("c2_s2_last", 2048, 0);
        bus.halt_R14H = 1'b0;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            samp("c2_s", c1x[i], c1y[i]);
        end
        @(negedge clk);
        idle_chk("c2_end");

        // case 3: degenerate box
        send(512, 512, 512, 512, 1024);
        samp("c3_s0", 512, 512);
        chk("c3_halt13", bus.halt_R13H, 1);
        @(negedge clk);
        idle_chk("c3_end");

        // case 4: illegal boxes are consumed and dropped
        @(negedge clk);
        load(1024, 0, 0, 0, 1024);
        bus.validTri_R13H = 1'b1;
        chk("c4_halt13_pre", bus.halt_R13H, 0);
        @(negedge clk);
        idle_chk("c4_a");
        chk("c4_hold_x", bus.sample_R14S[0], 512);
        load(0, 0, 0, 0, 0);
        @(negedge clk);
        idle_chk("c4_step0");
        bus.validTri_R13H = 1'b0;
        @(negedge clk);
        idle_chk("c4_end");

        // case 5: negative coordinates
        send(-2048, -1024, -1024, -1024, 1024);
        samp("c5_s0", -2048, -1024);
        @(negedge clk);
        samp("c5_s1", -1024, -1024);
        @(negedge clk);
        idle_chk("c5_end");

        // unaligned upper-right: 1500 is not reached
        send(0, 0, 1500, 0, 1024);
        samp("c7_s0", 0, 0);
        @(negedge clk);
        samp("c7_s1", 1024, 0);
        @(negedge clk);
        idle_chk("c7_end");

        // x step past most positive coordinate must not wrap
        send(8387584, 0, 8388607, 0, 1024);
        samp("c8_s0", 8387584, 0);
        @(negedge clk);
        idle_chk("c8_end");

        // case 6: async reset mid-iteration
        fill(4);
        send(0, 0, 2048, 1024, 1024);
        samp("c6_s0", 0, 0);
        @(negedge clk);
        samp("c6_s1", 1024, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("c6_rst_valid", bus.validSamp_R14H, 0);
        chk("c6_rst_sample", bus.sample_R14S, 0);
        chk("c6_rst_tri", bus.tri_R14S, 0);
        chk("c6_rst_color", bus.color_R14U, 0);
        chk("c6_rst_halt13", bus.halt_R13H, 0);
        @(negedge clk);
        chk("c6_rst_held", bus.validSamp_R14H, 0);
        rst = 1'b1;
        send(1024, 2048, 1024, 2048, 512);
        samp("c6_new", 1024, 2048);
        @(negedge clk);
        idle_chk("c6_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
